// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core
// Countdown timer core fed by single-cycle button edge flags. Holds an MM:SS
// value as four BCD digits, loads it with +1 s / +10 s, counts it down once
// per second while running and flags done when the countdown reaches 00:00.

module stopwatch_timer_core #(
    parameter int unsigned TICKS_PER_SEC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_pulse,
    input  logic       ten_pulse,
    input  logic       pause_pulse,
    input  logic       clear_pulse,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    typedef struct packed {
        logic [3:0] minTens;
        logic [3:0] minOnes;
        logic [3:0] secTens;
        logic [3:0] secOnes;
    } bcdTimeT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } stateT;

    localparam bcdTimeT TIME_ZERO = '{minTens: 4'd0, minOnes: 4'd0, secTens: 4'd0, secOnes: 4'd0};
    localparam bcdTimeT TIME_MAX  = '{minTens: 4'd9, minOnes: 4'd9, secTens: 4'd5, secOnes: 4'd9};

    stateT         state_q, state_d;
    bcdTimeT       time_q, time_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          running_q;
    logic          done_q;

    bcdTimeT       addTime;
    bcdTimeT       decTime;
    logic          anyAdd;

    // BCD add of the one/ten flags: +1 enters at the seconds ones digit, +10 at
    // the seconds tens digit, carries ripple upward and a carry out of the
    // minutes tens digit saturates the whole value at 99:59.
    always_comb begin
        logic [4:0] soSum;
        logic [4:0] stSum;
        logic [4:0] moSum;
        logic [4:0] mtSum;
        logic       c0;
        logic       c1;
        logic       c2;
        bcdTimeT    raw;

        raw    = time_q;
        anyAdd = one_pulse | ten_pulse;

        soSum = {1'b0, time_q.secOnes} + {4'b0000, one_pulse};
        c0    = (soSum > 5'd9);
        raw.secOnes = c0 ? 4'(soSum - 5'd10) : soSum[3:0];

        stSum = {1'b0, time_q.secTens} + {4'b0000, ten_pulse} + {4'b0000, c0};
        c1    = (stSum > 5'd5);
        raw.secTens = c1 ? 4'(stSum - 5'd6) : stSum[3:0];

        moSum = {1'b0, time_q.minOnes} + {4'b0000, c1};
        c2    = (moSum > 5'd9);
        raw.minOnes = c2 ? 4'(moSum - 5'd10) : moSum[3:0];

        mtSum = {1'b0, time_q.minTens} + {4'b0000, c2};
        raw.minTens = mtSum[3:0];

        addTime = (mtSum > 5'd9) ? TIME_MAX : raw;
    end

    // One-second BCD decrement with borrows running the reverse way through
    // the digits; only used when the time is known to be non-zero.
    always_comb begin
        decTime = time_q;
        if (time_q.secOnes != 4'd0) begin
            decTime.secOnes = time_q.secOnes - 4'd1;
        end else begin
            decTime.secOnes = 4'd9;
            if (time_q.secTens != 4'd0) begin
                decTime.secTens = time_q.secTens - 4'd1;
            end else begin
                decTime.secTens = 4'd5;
                if (time_q.minOnes != 4'd0) begin
                    decTime.minOnes = time_q.minOnes - 4'd1;
                end else begin
                    decTime.minOnes = 4'd9;
                    decTime.minTens = time_q.minTens - 4'd1;
                end
            end
        end
    end

    // Next state of the control FSM, time value and prescaler; clear beats
    // pause and pause beats any add arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pre_d   = pre_q;

        if (clear_pulse) begin
            state_d = IDLE;
            time_d  = TIME_ZERO;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pause_pulse) begin
                        if (time_q != TIME_ZERO) begin
                            state_d = RUN;
                            pre_d   = '0;
                        end
                    end else if (anyAdd) begin
                        time_d = addTime;
                    end
                end
                RUN: begin
                    if (pause_pulse) begin
                        state_d = PAUSED;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        time_d = decTime;
                        if (decTime == TIME_ZERO) begin
                            state_d = DONE;
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (pause_pulse) begin
                        state_d = RUN;
                    end else if (anyAdd) begin
                        time_d = addTime;
                    end
                end
                DONE: begin
                    time_d = TIME_ZERO;
                    pre_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                    time_d  = TIME_ZERO;
                    pre_d   = '0;
                end
            endcase
        end
    end

    // State registers plus registered running/done flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            time_q    <= TIME_ZERO;
            pre_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            pre_q     <= pre_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign min_tens = time_q.minTens;
    assign min_ones = time_q.minOnes;
    assign sec_tens = time_q.secTens;
    assign sec_ones = time_q.secOnes;
    assign running  = running_q;
    assign done     = done_q;

endmodule
